// File: rtl/metaframe_scheduler.sv
// Metaframe framing scheduler: interleaves sync, scrambler-state, skip and
// diagnostic control words with upstream payload words for a 64B/67B encoder.
module metaframe_scheduler #(
    parameter int unsigned METAFRAME_LEN = 2048,
    parameter logic [63:0] SYNC_WORD     = 64'h78F6_78F6_78F6_78F6,
    parameter logic [63:0] SKIP_WORD     = 64'h1E1E_1E1E_1E1E_1E1E,
    parameter logic [63:0] IDLE_WORD     = 64'h1C00_0000_0000_0000
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic        ENABLE,
    input  logic [57:0] SCRAM_STATE_IN,
    input  logic [1:0]  LANE_STATUS,
    input  logic [63:0] DATA_IN,
    input  logic [1:0]  HEADER_IN,
    input  logic        DATA_IN_VALID,
    output logic        DATA_IN_READY,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        DATA_OUT_VALID,
    output logic        ENC_PASSTHROUGH,
    output logic        METAFRAME_START
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(METAFRAME_LEN - 2);
    localparam logic [1:0] CTRL_HDR = 2'b10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_SCRAM   = 3'd2;
    localparam logic [2:0] ST_SKIP    = 3'd3;
    localparam logic [2:0] ST_PAYLOAD = 3'd4;
    localparam logic [2:0] ST_DIAG    = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_cnt_nxt;
    logic [63:0]      data_nxt;
    logic [1:0]       hdr_nxt;

    // Payload slots are open only in PAYLOAD; upstream valid never gates this.
    assign DATA_IN_READY = (state == ST_PAYLOAD);

    // Slot sequencing and the word each state emits one cycle later.
    always_comb begin
        state_nxt    = state;
        slot_cnt_nxt = slot_cnt;
        data_nxt     = 64'd0;
        hdr_nxt      = 2'b00;
        case (state)
            ST_IDLE: begin
                slot_cnt_nxt = '0;
                if (ENABLE) begin
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                hdr_nxt      = CTRL_HDR;
                data_nxt     = SYNC_WORD;
                state_nxt    = ST_SCRAM;
                slot_cnt_nxt = slot_cnt + CNT_W'(1);
            end
            ST_SCRAM: begin
                hdr_nxt      = CTRL_HDR;
                data_nxt     = {6'b001010, SCRAM_STATE_IN};
                state_nxt    = ST_SKIP;
                slot_cnt_nxt = slot_cnt + CNT_W'(1);
            end
            ST_SKIP: begin
                hdr_nxt      = CTRL_HDR;
                data_nxt     = SKIP_WORD;
                state_nxt    = ST_PAYLOAD;
                slot_cnt_nxt = slot_cnt + CNT_W'(1);
            end
            ST_PAYLOAD: begin
                if (DATA_IN_VALID) begin
                    hdr_nxt  = HEADER_IN;
                    data_nxt = DATA_IN;
                end else begin
                    hdr_nxt  = CTRL_HDR;
                    data_nxt = IDLE_WORD;
                end
                slot_cnt_nxt = slot_cnt + CNT_W'(1);
                if (slot_cnt == LAST_PAYLOAD) begin
                    state_nxt = ST_DIAG;
                end
            end
            ST_DIAG: begin
                // Status sits at bits 33:32; CRC32 in 31:0 is inserted downstream.
                hdr_nxt      = CTRL_HDR;
                data_nxt     = {6'b011001, 24'd0, LANE_STATUS, 32'd0};
                slot_cnt_nxt = '0;
                state_nxt    = ENABLE ? ST_SYNC : ST_IDLE;
            end
            default: begin
                state_nxt    = ST_IDLE;
                slot_cnt_nxt = '0;
            end
        endcase
    end

    // State, slot counter and registered encoder-facing outputs.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state           <= ST_IDLE;
            slot_cnt        <= '0;
            DATA_OUT        <= 64'd0;
            HEADER_OUT      <= 2'b00;
            DATA_OUT_VALID  <= 1'b0;
            METAFRAME_START <= 1'b0;
            ENC_PASSTHROUGH <= 1'b1;
        end else begin
            state           <= state_nxt;
            slot_cnt        <= slot_cnt_nxt;
            DATA_OUT        <= data_nxt;
            HEADER_OUT      <= hdr_nxt;
            DATA_OUT_VALID  <= (state != ST_IDLE);
            METAFRAME_START <= (state == ST_SYNC);
            ENC_PASSTHROUGH <= (state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_metaframe_scheduler.sv
// Directed bench for metaframe_scheduler with METAFRAME_LEN=8: vector table
// for two metaframes plus hand sequences for async reset and back-to-back frames.
module tb_metaframe_scheduler;

    localparam logic [63:0] SW  = 64'h78F6_78F6_78F6_78F6;
    localparam logic [63:0] SKW = 64'h1E1E_1E1E_1E1E_1E1E;
    localparam logic [63:0] IW  = 64'h1C00_0000_0000_0000;
    localparam logic [63:0] SCW = 64'h2AAA_AAAA_AAAA_AAAA;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [57:0] scram;
    logic [1:0]  ls;
    logic [63:0] din;
    logic [1:0]  hin;
    logic        dv;
    logic        rdy;
    logic [63:0] dout;
    logic [1:0]  hout;
    logic        vout;
    logic        pt;
    logic        start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic        dv;
        logic [1:0]  hin;
        logic [63:0] din;
        logic [1:0]  ls;
        logic        e_rdy;
        logic        e_val;
        logic [1:0]  e_hdr;
        logic [63:0] e_data;
        logic        e_start;
        logic        e_pt;
    } vec_t;

    vec_t vt[$];

    metaframe_scheduler #(.METAFRAME_LEN(8)) dut (
        .USER_CLK        (clk),
        .SYSTEM_RESET_N  (rst_n),
        .ENABLE          (en),
        .SCRAM_STATE_IN  (scram),
        .LANE_STATUS     (ls),
        .DATA_IN         (din),
        .HEADER_IN       (hin),
        .DATA_IN_VALID   (dv),
        .DATA_IN_READY   (rdy),
        .DATA_OUT        (dout),
        .HEADER_OUT      (hout),
        .DATA_OUT_VALID  (vout),
        .ENC_PASSTHROUGH (pt),
        .METAFRAME_START (start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_val, input logic [1:0] e_hdr,
                            input logic [63:0] e_data, input logic e_start, input logic e_pt);
        chk({tag, "_valid"}, 64'(vout), 64'(e_val));
        chk({tag, "_hdr"}, 64'(hout), 64'(e_hdr));
        chk({tag, "_data"}, dout, e_data);
        chk({tag, "_start"}, 64'(start), 64'(e_start));
        chk({tag, "_pt"}, 64'(pt), 64'(e_pt));
    endtask

    function automatic vec_t mk(input logic v_en, input logic v_dv, input logic [1:0] v_hin,
                                input logic [63:0] v_din, input logic [1:0] v_ls,
                                input logic r, input logic v, input logic [1:0] h,
                                input logic [63:0] d, input logic s, input logic p);
        vec_t x;
        x.en = v_en; x.dv = v_dv; x.hin = v_hin; x.din = v_din; x.ls = v_ls;
        x.e_rdy = r; x.e_val = v; x.e_hdr = h; x.e_data = d; x.e_start = s; x.e_pt = p;
        return x;
    endfunction

    initial begin
        // Inputs for one cycle, ready seen in that cycle, outputs after its edge.
        vt.push_back(mk(1, 0, 2'b00, 64'h0,                   2'b00, 0, 0, 2'b00, 64'h0, 0, 1));
        vt.push_back(mk(1, 1, 2'b01, 64'hDEAD_0000_0000_0001, 2'b00, 0, 1, 2'b10, SW,    1, 0));
        vt.push_back(mk(1, 1, 2'b01, 64'hBEEF_0000_0000_0002, 2'b00, 0, 1, 2'b10, SCW,   0, 0));
        vt.push_back(mk(1, 0, 2'b00, 64'h0,                   2'b00, 0, 1, 2'b10, SKW,   0, 0));
        vt.push_back(mk(1, 1, 2'b01, 64'h0123_4567_89AB_CDEF, 2'b00, 1, 1, 2'b01, 64'h0123_4567_89AB_CDEF, 0, 0));
        vt.push_back(mk(1, 0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 1, 2'b10, IW,    0, 0));
        vt.push_back(mk(1, 1, 2'b10, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00, 1, 1, 2'b10, 64'hA5A5_A5A5_5A5A_5A5A, 0, 0));
        vt.push_back(mk(1, 1, 2'b00, 64'h1111_2222_3333_4444, 2'b00, 1, 1, 2'b00, 64'h1111_2222_3333_4444, 0, 0));
        vt.push_back(mk(1, 0, 2'b00, 64'h0,                   2'b01, 0, 1, 2'b10, 64'h6400_0001_0000_0000, 0, 0));
        vt.push_back(mk(0, 0, 2'b00, 64'h0,                   2'b00, 0, 1, 2'b10, SW,    1, 0));
        vt.push_back(mk(0, 1, 2'b11, 64'h9999_9999_9999_9999, 2'b00, 0, 1, 2'b10, SCW,   0, 0));
        vt.push_back(mk(1, 0, 2'b00, 64'h0,                   2'b00, 0, 1, 2'b10, SKW,   0, 0));
        vt.push_back(mk(0, 1, 2'b01, 64'h0000_0000_0000_0003, 2'b00, 1, 1, 2'b01, 64'h0000_0000_0000_0003, 0, 0));
        vt.push_back(mk(0, 1, 2'b01, 64'h0000_0000_0000_0004, 2'b00, 1, 1, 2'b01, 64'h0000_0000_0000_0004, 0, 0));
        vt.push_back(mk(0, 1, 2'b01, 64'h0000_0000_0000_0005, 2'b00, 1, 1, 2'b01, 64'h0000_0000_0000_0005, 0, 0));
        vt.push_back(mk(0, 1, 2'b01, 64'h0000_0000_0000_0006, 2'b00, 1, 1, 2'b01, 64'h0000_0000_0000_0006, 0, 0));
        vt.push_back(mk(0, 0, 2'b00, 64'h0,                   2'b11, 0, 1, 2'b10, 64'h6400_0003_0000_0000, 0, 0));
        vt.push_back(mk(0, 1, 2'b01, 64'h7777_7777_7777_7777, 2'b00, 0, 0, 2'b00, 64'h0, 0, 1));
        vt.push_back(mk(0, 0, 2'b00, 64'h0,                   2'b00, 0, 0, 2'b00, 64'h0, 0, 1));

        rst_n = 1'b0; en = 1'b0; dv = 1'b0; din = '0; hin = '0; ls = '0;
        scram = 58'h2AA_AAAA_AAAA_AAAA;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(rdy), 64'd0);
        chk_outs("reset", 0, 2'b00, 64'h0, 0, 1);
        #2 rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            en = vt[i].en; dv = vt[i].dv; hin = vt[i].hin; din = vt[i].din; ls = vt[i].ls;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(rdy), 64'(vt[i].e_rdy));
            @(posedge clk);
            #1;
            chk_outs($sformatf("v%0d", i), vt[i].e_val, vt[i].e_hdr, vt[i].e_data,
                     vt[i].e_start, vt[i].e_pt);
        end

        // Async reset asserted and released mid-cycle during payload.
        en = 1'b1; dv = 1'b1; hin = 2'b01; din = 64'hCAFE_F00D_CAFE_F00D; ls = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_ready", 64'(rdy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(rdy), 64'd0);
        chk_outs("async_rst", 0, 2'b00, 64'h0, 0, 1);
        @(posedge clk);
        #1;
        chk_outs("rst_held", 0, 2'b00, 64'h0, 0, 1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst1_ready", 64'(rdy), 64'd0);
        chk_outs("post_rst1", 0, 2'b00, 64'h0, 0, 1);
        @(posedge clk);
        #1;
        chk_outs("post_rst_sync", 1, 2'b10, SW, 1, 0);

        // Back-to-back metaframes with constant valid payload.
        for (int i = 1; i < 24; i++) begin
            int slot;
            int nslot;
            logic [63:0] ed;
            logic [1:0]  eh;
            slot  = i % 8;
            nslot = (i + 1) % 8;
            eh = 2'b10;
            case (slot)
                0: ed = SW;
                1: ed = SCW;
                2: ed = SKW;
                7: ed = 64'h6400_0000_0000_0000;
                default: begin ed = din; eh = 2'b01; end
            endcase
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_ready", i), 64'(rdy), 64'((nslot >= 3) && (nslot <= 6)));
            chk_outs($sformatf("b2b%0d", i), 1, eh, ed, (slot == 0), 0);
        end

        // Drop enable right at a sync slot; the frame still completes.
        en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk_outs("drain_diag", 1, 2'b10, 64'h6400_0000_0000_0000, 0, 0);
        @(posedge clk);
        #1;
        chk_outs("drain_idle", 0, 2'b00, 64'h0, 0, 1);
        @(posedge clk);
        #1;
        chk_outs("stay_idle", 0, 2'b00, 64'h0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
